// File: rtl/m68k_bridge_pkg.sv
// Shared constants and encodings for the 68000 bus-to-host bridge.
package m68k_bridge_pkg;

    // Host command bytes
    localparam logic [7:0] CMD_BOTH   = 8'h42; // 'B': lo byte then hi byte follow
    localparam logic [7:0] CMD_LO     = 8'h4C; // 'L': lo byte follows
    localparam logic [7:0] CMD_HI     = 8'h48; // 'H': hi byte follows
    localparam logic [7:0] CMD_DTACK  = 8'h44; // 'D': terminate with DTACK
    localparam logic [7:0] CMD_BERR   = 8'h45; // 'E': terminate with BERR
    localparam logic [7:0] CMD_RESEND = 8'h52; // 'R': retransmit captured record

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [1:0] {C_IDLE, C_PENDING, C_DONE} cyc_state_t;
    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_B_LO, RX_HI, RX_LO} rx_state_t;

    // Signal byte sent after the address bytes
    typedef struct packed {
        logic [1:0] rsvd;
        logic [2:0] fc;
        logic       rw;
        logic       uds;
        logic       lds;
    } sig_byte_t;

    function automatic sig_byte_t make_sig(input logic [2:0] fc, input logic rw,
                                           input logic uds, input logic lds);
        sig_byte_t s;
        s.rsvd = 2'b00;
        s.fc   = fc;
        s.rw   = rw;
        s.uds  = uds;
        s.lds  = lds;
        return s;
    endfunction

endpackage

// File: rtl/m68k_bridge_cmd_rx.sv
// Host command parser: decodes the UART byte stream into load and
// termination strobes. Strobes are combinational on the rx_new cycle.
module m68k_bridge_cmd_rx
    import m68k_bridge_pkg::*;
(
    input  logic       clk_sys,
    input  logic       i_rst,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_new,
    output logic       o_load_lo,
    output logic       o_load_hi,
    output logic [7:0] o_byte,
    output logic       o_cmd_dtack,
    output logic       o_cmd_berr,
    output logic       o_cmd_resend
);

    rx_state_t r_state;
    logic      w_cmd_byte;

    // Only bytes seen in RX_IDLE are commands; data bytes are consumed raw.
    assign w_cmd_byte   = i_rx_new && (r_state == RX_IDLE);
    assign o_cmd_dtack  = w_cmd_byte && (i_rx_data == CMD_DTACK);
    assign o_cmd_berr   = w_cmd_byte && (i_rx_data == CMD_BERR);
    assign o_cmd_resend = w_cmd_byte && (i_rx_data == CMD_RESEND);
    assign o_load_lo    = i_rx_new && ((r_state == RX_B_LO) || (r_state == RX_LO));
    assign o_load_hi    = i_rx_new && (r_state == RX_HI);
    assign o_byte       = i_rx_data;

    // Parser state: advances only on received bytes
    always_ff @(posedge clk_sys) begin
        if (i_rst) begin
            r_state <= RX_IDLE;
        end else if (i_rx_new) begin
            case (r_state)
                RX_IDLE: begin
                    case (i_rx_data)
                        CMD_BOTH: r_state <= RX_B_LO;
                        CMD_LO:   r_state <= RX_LO;
                        CMD_HI:   r_state <= RX_HI;
                        default:  r_state <= RX_IDLE;
                    endcase
                end
                RX_B_LO: r_state <= RX_HI;
                default: r_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/m68k_bus_bridge.sv
// 68000 bus-to-host bridge: captures each bus cycle, sends a framed record
// to the host over the UART and terminates the cycle on host command or
// hardware timeout.
module m68k_bus_bridge
    import m68k_bridge_pkg::*;
#(
    parameter int          ADDR_W         = 24,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int          TIMEOUT_CYCLES = 50000000
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic              bus_reset,
    input  logic              bus_as,
    input  logic              bus_uds,
    input  logic              bus_lds,
    input  logic              bus_rw,
    input  logic [2:0]        bus_fc,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [15:0]       bus_din,
    output logic [15:0]       bus_dout,
    output logic              dtack,
    output logic              berr,
    output logic [7:0]        tx_data,
    output logic              tx_new,
    input  logic              tx_busy,
    input  logic [7:0]        rx_data,
    input  logic              rx_new,
    output logic              cycle_pending,
    output logic              timeout_evt
);

    localparam int ADDR_BYTES = (ADDR_W + 7) / 8;
    localparam int PAD_W      = ADDR_BYTES * 8;
    localparam int FRAME_LEN  = ADDR_BYTES + 4;
    localparam int IDX_W      = $clog2(FRAME_LEN);
    localparam int CNT_W      = $clog2(TIMEOUT_CYCLES) + 1;
    localparam bit TO_EN      = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    logic              w_rst;
    logic              w_strobe_now, w_strobe_rise, w_as_fall;
    logic              r_strobe_prev, r_as_prev;
    logic              w_load_lo, w_load_hi, w_cmd_dtack, w_cmd_berr, w_cmd_resend;
    logic [7:0]        w_rx_byte;
    logic              w_timeout, w_start_cyc, w_resend_ok, w_tx_start, w_tx_new;
    logic [7:0]        w_tx_byte;
    logic [PAD_W-1:0]  w_addr_pad;

    cyc_state_t        r_cstate;
    tx_state_t         r_tx_state;
    logic [IDX_W-1:0]  r_tx_idx;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_dtack, r_berr, r_timeout_evt;
    logic [15:0]       r_dout;
    logic [ADDR_W-1:0] r_cap_addr;
    sig_byte_t         r_cap_sig;
    logic [15:0]       r_cap_data;

    assign w_rst         = rst | bus_reset;
    assign w_strobe_now  = bus_uds | bus_lds;
    assign w_strobe_rise = w_strobe_now & ~r_strobe_prev;
    assign w_as_fall     = ~bus_as & r_as_prev;
    assign w_start_cyc   = (r_cstate == C_IDLE) && w_strobe_rise;
    assign w_timeout     = TO_EN && (r_cstate == C_PENDING) && (r_cnt == TO_LAST);
    assign w_resend_ok   = w_cmd_resend && (r_cstate == C_PENDING) && (r_tx_state == TX_IDLE);
    assign w_tx_start    = w_start_cyc || w_resend_ok;
    assign w_tx_new      = (r_tx_state == TX_SEND) && !tx_busy;
    assign w_addr_pad    = PAD_W'(r_cap_addr);

    m68k_bridge_cmd_rx u_cmd_rx (
        .clk_sys      (clk_sys),
        .i_rst        (w_rst),
        .i_rx_data    (rx_data),
        .i_rx_new     (rx_new),
        .o_load_lo    (w_load_lo),
        .o_load_hi    (w_load_hi),
        .o_byte       (w_rx_byte),
        .o_cmd_dtack  (w_cmd_dtack),
        .o_cmd_berr   (w_cmd_berr),
        .o_cmd_resend (w_cmd_resend)
    );

    // Edge history follows the bus even in reset, so a strobe held through
    // reset is not mistaken for a new cycle afterwards.
    always_ff @(posedge clk_sys) begin
        r_strobe_prev <= w_strobe_now;
        r_as_prev     <= bus_as;
    end

    // Cycle FSM: capture, host/timeout termination, release on AS negation
    always_ff @(posedge clk_sys) begin
        if (w_rst) begin
            r_cstate      <= C_IDLE;
            r_dtack       <= 1'b0;
            r_berr        <= 1'b0;
            r_timeout_evt <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_timeout_evt <= 1'b0;
            case (r_cstate)
                C_IDLE: begin
                    if (w_strobe_rise) begin
                        r_cstate <= C_PENDING;
                        r_cnt    <= '0;
                    end
                end
                C_PENDING: begin
                    if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
                    // Host command outranks a coincident timeout
                    if (w_as_fall) begin
                        r_cstate <= C_IDLE;
                    end else if (w_cmd_dtack) begin
                        r_dtack  <= 1'b1;
                        r_cstate <= C_DONE;
                    end else if (w_cmd_berr) begin
                        r_berr   <= 1'b1;
                        r_cstate <= C_DONE;
                    end else if (w_timeout) begin
                        r_berr        <= 1'b1;
                        r_timeout_evt <= 1'b1;
                        r_cstate      <= C_DONE;
                    end
                end
                C_DONE: begin
                    if (w_as_fall) begin
                        r_dtack  <= 1'b0;
                        r_berr   <= 1'b0;
                        r_cstate <= C_IDLE;
                    end
                end
                default: r_cstate <= C_IDLE;
            endcase
        end
    end

    // Capture register loaded at the start of each bus cycle
    always_ff @(posedge clk_sys) begin
        if (w_rst) begin
            r_cap_addr <= '0;
            r_cap_sig  <= '0;
            r_cap_data <= '0;
        end else if (w_start_cyc) begin
            r_cap_addr <= bus_addr;
            r_cap_sig  <= make_sig(bus_fc, bus_rw, bus_uds, bus_lds);
            r_cap_data <= bus_din;
        end
    end

    // TX frame sequencer: only reset can cut a frame short
    always_ff @(posedge clk_sys) begin
        if (w_rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_idx   <= '0;
        end else if (w_tx_start) begin
            r_tx_state <= TX_SEND;
            r_tx_idx   <= '0;
        end else if (w_tx_new) begin
            if (r_tx_idx == IDX_W'(FRAME_LEN - 1)) begin
                r_tx_state <= TX_IDLE;
                r_tx_idx   <= '0;
            end else begin
                r_tx_idx <= r_tx_idx + IDX_W'(1);
            end
        end
    end

    // Frame byte mux: sync, address MSB first, signal byte, data hi, data lo
    always_comb begin
        w_tx_byte = 8'h00;
        if (r_tx_state == TX_SEND) begin
            if (r_tx_idx == '0) w_tx_byte = SYNC_BYTE;
            for (int k = 0; k < ADDR_BYTES; k++) begin
                if (r_tx_idx == IDX_W'(ADDR_BYTES - k)) w_tx_byte = w_addr_pad[k*8 +: 8];
            end
            if (r_tx_idx == IDX_W'(ADDR_BYTES + 1)) w_tx_byte = r_cap_sig;
            if (r_tx_idx == IDX_W'(ADDR_BYTES + 2)) w_tx_byte = r_cap_data[15:8];
            if (r_tx_idx == IDX_W'(ADDR_BYTES + 3)) w_tx_byte = r_cap_data[7:0];
        end
    end

    // Read-data buffer, held across cycles until the host reloads it
    always_ff @(posedge clk_sys) begin
        if (w_rst) begin
            r_dout <= '0;
        end else begin
            if (w_load_lo) r_dout[7:0]  <= w_rx_byte;
            if (w_load_hi) r_dout[15:8] <= w_rx_byte;
        end
    end

    assign bus_dout      = r_dout;
    assign dtack         = r_dtack;
    assign berr          = r_berr;
    assign timeout_evt   = r_timeout_evt;
    assign cycle_pending = (r_cstate == C_PENDING);
    assign tx_new        = w_tx_new;
    assign tx_data       = w_tx_byte;

endmodule

// File: tb/tb_m68k_bus_bridge.sv
// Directed bench for m68k_bus_bridge: TX bytes are checked against a
// queue of expected frame bytes, cycle outputs against fixed expectations.
module tb_m68k_bus_bridge;

    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic        bus_reset = 1'b0;
    logic        bus_as = 1'b0, bus_uds = 1'b0, bus_lds = 1'b0, bus_rw = 1'b0;
    logic [2:0]  bus_fc = 3'd0;
    logic [23:0] bus_addr = 24'd0;
    logic [15:0] bus_din = 16'd0;
    logic        tx_busy;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_new = 1'b0;
    logic [15:0] bus_dout;
    logic        dtack, berr, tx_new, cycle_pending, timeout_evt;
    logic [7:0]  tx_data;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    bit          tog_en = 1'b0;

    m68k_bus_bridge #(.ADDR_W(24), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(100)) dut (
        .clk_sys(clk_sys), .rst(rst), .bus_reset(bus_reset),
        .bus_as(bus_as), .bus_uds(bus_uds), .bus_lds(bus_lds), .bus_rw(bus_rw),
        .bus_fc(bus_fc), .bus_addr(bus_addr), .bus_din(bus_din), .bus_dout(bus_dout),
        .dtack(dtack), .berr(berr), .tx_data(tx_data), .tx_new(tx_new),
        .tx_busy(tx_busy), .rx_data(rx_data), .rx_new(rx_new),
        .cycle_pending(cycle_pending), .timeout_evt(timeout_evt)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic rx_send(input logic [7:0] b);
        rx_data = b;
        rx_new  = 1'b1;
        step(1);
        rx_new  = 1'b0;
    endtask

    task automatic start_cycle(input logic [23:0] a, input logic [2:0] fc, input logic rw,
                               input logic uds, input logic lds, input logic [15:0] d);
        bus_addr = a; bus_fc = fc; bus_rw = rw; bus_din = d;
        bus_as = 1'b1; bus_uds = uds; bus_lds = lds;
        step(1);
    endtask

    task automatic end_cycle();
        bus_as = 1'b0; bus_uds = 1'b0; bus_lds = 1'b0;
        step(1);
    endtask

    function automatic void push_frame(input logic [23:0] a, input logic [2:0] fc, input logic rw,
                                       input logic uds, input logic lds, input logic [15:0] d);
        exp_q.push_back(8'hA5);
        exp_q.push_back(a[23:16]);
        exp_q.push_back(a[15:8]);
        exp_q.push_back(a[7:0]);
        exp_q.push_back({2'b00, fc, rw, uds, lds});
        exp_q.push_back(d[15:8]);
        exp_q.push_back(d[7:0]);
    endfunction

    // Bounded wait for the expected frame bytes to drain, then idle a bit
    // so any surplus byte is caught by the monitor.
    task automatic wait_q_empty(input string tag, input int max);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin
            step(1);
            n++;
        end
        chk(tag, exp_q.size(), 0);
        step(3);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dtack"}, dtack, 0);
        chk({tag, "_berr"}, berr, 0);
        chk({tag, "_dout"}, bus_dout, 0);
        chk({tag, "_txnew"}, tx_new, 0);
        chk({tag, "_txdata"}, tx_data, 0);
        chk({tag, "_pend"}, cycle_pending, 0);
        chk({tag, "_tmo"}, timeout_evt, 0);
    endtask

    // UART busy: held low, or toggled every cycle when tog_en is set
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge clk_sys);
            #1;
            tx_busy = tog_en ? ~tx_busy : 1'b0;
        end
    end

    // TX monitor: each presented byte must be expected and never under busy
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk_sys);
            if (tx_new === 1'b1) begin
                chk("tx_while_busy", tx_busy, 0);
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL tx_extra observed=%02h expected=no byte", tx_data);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("tx_byte", tx_data, e);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        step(3);
        chk_all_zero("reset");
        rst = 1'b0;
        step(1);

        // 1: read 0x012345, FC=5, both strobes; host loads 0x1234 then DTACK
        exp_q.push_back(8'hA5); exp_q.push_back(8'h01); exp_q.push_back(8'h23);
        exp_q.push_back(8'h45); exp_q.push_back(8'h2F); exp_q.push_back(8'hC0);
        exp_q.push_back(8'hDE);
        start_cycle(24'h012345, 3'd5, 1'b1, 1'b1, 1'b1, 16'hC0DE);
        chk("t1_pending", cycle_pending, 1);
        wait_q_empty("t1_frame", 20);
        rx_send(8'h42); rx_send(8'h34); rx_send(8'h12);
        chk("t1_dout", bus_dout, 16'h1234);
        chk("t1_dtack_pre", dtack, 0);
        rx_send(8'h44);
        chk("t1_dtack", dtack, 1);
        chk("t1_pend_done", cycle_pending, 0);
        step(2);
        chk("t1_dtack_hold", dtack, 1);
        end_cycle();
        chk("t1_dtack_clr", dtack, 0);
        step(2);

        // 2: write 0xBEEF at 0x000100, LDS only, UART busy alternating
        tog_en = 1'b1;
        exp_q.push_back(8'hA5); exp_q.push_back(8'h00); exp_q.push_back(8'h01);
        exp_q.push_back(8'h00); exp_q.push_back(8'h29); exp_q.push_back(8'hBE);
        exp_q.push_back(8'hEF);
        start_cycle(24'h000100, 3'd5, 1'b0, 1'b0, 1'b1, 16'hBEEF);
        wait_q_empty("t2_frame", 40);
        tog_en = 1'b0;
        step(1);
        rx_send(8'h45);
        chk("t2_berr", berr, 1);
        chk("t2_dtack", dtack, 0);
        chk("t2_dout_held", bus_dout, 16'h1234);
        end_cycle();
        chk("t2_berr_clr", berr, 0);
        step(2);

        // 3: no reply -> timeout BERR 100 cycles after the strobe edge
        push_frame(24'h00ABCD, 3'd2, 1'b1, 1'b1, 1'b0, 16'h1111);
        start_cycle(24'h00ABCD, 3'd2, 1'b1, 1'b1, 1'b0, 16'h1111);
        step(99);
        chk("t3_berr_early", berr, 0);
        chk("t3_tmo_early", timeout_evt, 0);
        step(1);
        chk("t3_berr", berr, 1);
        chk("t3_tmo", timeout_evt, 1);
        chk("t3_dtack", dtack, 0);
        step(1);
        chk("t3_tmo_pulse", timeout_evt, 0);
        chk("t3_frame", exp_q.size(), 0);
        rx_send(8'h44);
        chk("t3_late_d", dtack, 0);
        chk("t3_berr_hold", berr, 1);
        end_cycle();
        chk("t3_berr_clr", berr, 0);
        step(2);

        // 4: 'D' on the very cycle the timeout would fire
        push_frame(24'h654321, 3'd6, 1'b1, 1'b1, 1'b1, 16'h2222);
        start_cycle(24'h654321, 3'd6, 1'b1, 1'b1, 1'b1, 16'h2222);
        step(99);
        rx_send(8'h44);
        chk("t4_dtack", dtack, 1);
        chk("t4_berr", berr, 0);
        chk("t4_tmo", timeout_evt, 0);
        step(1);
        chk("t4_tmo_after", timeout_evt, 0);
        chk("t4_frame", exp_q.size(), 0);
        end_cycle();
        step(2);

        // 5: 'R' mid-frame ignored, 'R' after frame resends, 'D' when idle ignored
        push_frame(24'h00F00D, 3'd1, 1'b1, 1'b1, 1'b1, 16'h5A3C);
        start_cycle(24'h00F00D, 3'd1, 1'b1, 1'b1, 1'b1, 16'h5A3C);
        rx_send(8'h52);
        wait_q_empty("t5_frame", 20);
        push_frame(24'h00F00D, 3'd1, 1'b1, 1'b1, 1'b1, 16'h5A3C);
        rx_send(8'h52);
        wait_q_empty("t5_resend", 20);
        chk("t5_pending", cycle_pending, 1);
        end_cycle();
        chk("t5_abort", cycle_pending, 0);
        rx_send(8'h44);
        chk("t5_idle_d", dtack, 0);
        chk("t5_idle_pend", cycle_pending, 0);
        step(3);

        // 6a: rst during address byte 2 with DTACK asserted
        exp_q.push_back(8'hA5); exp_q.push_back(8'h12); exp_q.push_back(8'h34);
        start_cycle(24'h123456, 3'd5, 1'b1, 1'b1, 1'b1, 16'h0000);
        rx_send(8'h44);
        chk("t6_dtack", dtack, 1);
        step(1);
        rst = 1'b1; bus_as = 1'b0; bus_uds = 1'b0; bus_lds = 1'b0;
        step(1);
        chk_all_zero("t6_rst");
        rst = 1'b0;
        step(4);
        chk("t6_abort_frame", exp_q.size(), 0);
        push_frame(24'h0000FF, 3'd5, 1'b0, 1'b1, 1'b1, 16'hA55A);
        start_cycle(24'h0000FF, 3'd5, 1'b0, 1'b1, 1'b1, 16'hA55A);
        wait_q_empty("t6_clean", 20);
        rx_send(8'h44);
        end_cycle();
        step(2);

        // 6b: same via bus_reset, with a nonzero read buffer first
        rx_send(8'h4C); rx_send(8'h77);
        chk("t6b_dout", bus_dout, 16'h0077);
        exp_q.push_back(8'hA5); exp_q.push_back(8'h9A); exp_q.push_back(8'hBC);
        start_cycle(24'h9ABCDE, 3'd5, 1'b1, 1'b1, 1'b1, 16'h0000);
        rx_send(8'h44);
        chk("t6b_dtack", dtack, 1);
        step(1);
        bus_reset = 1'b1; bus_as = 1'b0; bus_uds = 1'b0; bus_lds = 1'b0;
        step(1);
        chk_all_zero("t6b_brst");
        bus_reset = 1'b0;
        step(4);
        chk("t6b_abort_frame", exp_q.size(), 0);
        push_frame(24'h00C0FE, 3'd1, 1'b1, 1'b0, 1'b1, 16'h1357);
        start_cycle(24'h00C0FE, 3'd1, 1'b1, 1'b0, 1'b1, 16'h1357);
        wait_q_empty("t6b_clean", 20);
        rx_send(8'h45);
        chk("t6b_berr", berr, 1);
        end_cycle();
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/m68k_bus_bridge.md
Name: m68k_bus_bridge

Overview:
- Parametrised bus-to-host bridge between synchronised 68000 bus signals and the AVR UART byte stream, all in the clk_sys domain.
- On each data strobe it captures address, FC, RW, strobes and data, then transmits a framed record.
- It then waits for a host command to load read data, terminate the cycle with DTACK or BERR, or retransmit the record.
- A hardware timeout terminates unanswered cycles with BERR.
- It replaces the fixed 24-bit, unframed, timeout-less bridge logic in the top level.

Parameters:
- ADDR_W, 24: width of captured address; ADDR_BYTES = ceil(ADDR_W/8) localparam, MSB zero-padded.
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT_CYCLES, 50000000: clk_sys cycles from strobe assertion to automatic BERR; 0 disables the timeout.

Ports:
- clk_sys  in  1  system clock
- rst  in  1  synchronous active-high reset
- bus_reset  in  1  68k RESET_out asserted, active-high; same effect as rst
- bus_as  in  1  address strobe asserted (synchronised, active-high)
- bus_uds  in  1  upper data strobe asserted
- bus_lds  in  1  lower data strobe asserted
- bus_rw  in  1  1 = read
- bus_fc  in  3  function code
- bus_addr  in  ADDR_W  address bus
- bus_din  in  16  data bus from CPU
- bus_dout  out  16  read-data buffer; top level gates it onto the pins
- dtack  out  1  DTACK asserted, active-high
- berr  out  1  BERR asserted, active-high
- tx_data  out  8  byte to UART
- tx_new  out  1  byte valid
- tx_busy  in  1  UART busy
- rx_data  in  8  byte from UART
- rx_new  in  1  one-cycle received-byte strobe
- cycle_pending  out  1  cycle captured, not yet terminated
- timeout_evt  out  1  one-cycle pulse on timeout BERR

Behaviour:
- Reset: rst or bus_reset drive the following; both are synchronous to clk_sys, and rst is active-high.
  - bus_dout=0, dtack=0, berr=0, tx_new=0, tx_data=0, cycle_pending=0, timeout_evt=0.
  - All FSMs go to idle.
  - Reset mid-frame aborts the frame immediately, with no further bytes.
- Edge detect: strobe_rise = (bus_uds|bus_lds) now and neither strobe asserted in the previous cycle; as_fall = bus_as falling edge.
- Cycle FSM states are C_IDLE, C_PENDING and C_DONE.
  - C_IDLE + strobe_rise -> C_PENDING. Same cycle: latch addr, fc, rw, uds, lds, din into the capture register, clear the timeout counter, start the TX frame.
  - C_PENDING + host 'D' -> dtack=1, C_DONE.
  - C_PENDING + host 'E' -> berr=1, C_DONE.
  - C_PENDING + counter == TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES != 0) -> berr=1, timeout_evt pulse, C_DONE.
  - Host command and timeout in the same cycle: the host command wins and no timeout_evt is raised.
  - C_DONE + as_fall -> dtack=0, berr=0, C_IDLE.
  - C_PENDING + as_fall (aborted cycle) -> C_IDLE, no termination.
  - A strobe_rise outside C_IDLE is ignored.
- cycle_pending = (state == C_PENDING).
- TX frame is SYNC_BYTE, then ADDR_BYTES address bytes MSB first, then {2'b0, fc, rw, uds, lds}, then data[15:8], then data[7:0].
  - tx_new = frame active & ~tx_busy; tx_data is combinational from the byte index.
  - The index advances on every cycle with tx_new=1; after the last byte the FSM returns to TX_IDLE.
  - Frame length is ADDR_BYTES+4 (7 at the default).
  - A frame is never truncated by cycle termination or as_fall; only reset aborts it.
- RX parser (states RX_IDLE, RX_B_LO, RX_HI, RX_LO): acts only when rx_new=1.
  - 'B'(0x42): the next byte loads bus_dout[7:0], the following byte loads bus_dout[15:8].
  - 'L'(0x4C): the next byte loads bus_dout[7:0].
  - 'H'(0x48): the next byte loads bus_dout[15:8].
  - Data bytes are consumed raw: command codes inside them are not interpreted.
  - 'D'(0x44) and 'E'(0x45) act only in C_PENDING and are ignored otherwise.
  - 'R'(0x52): restarts the frame from captured data, only if C_PENDING and TX idle; ignored otherwise.
  - Unknown bytes in RX_IDLE are ignored.
  - bus_dout holds its value across cycles until reloaded.
- Timeout counter: width is clog2(TIMEOUT_CYCLES)+1; it saturates and counts only in C_PENDING.

Decomposition:
- Package m68k_bridge_pkg holds:
  - command byte constants (CMD_BOTH, CMD_LO, CMD_HI, CMD_DTACK, CMD_BERR, CMD_RESEND);
  - the SYNC_BYTE default;
  - cycle, TX and RX state encodings;
  - the signal-byte field layout.
- Sub-module m68k_bridge_cmd_rx contains the RX parser. It outputs load_lo, load_hi, byte, cmd_dtack, cmd_berr and cmd_resend strobes.

Test Plan:
- Read at 0x012345, FC=5, UDS+LDS, tx_busy low, then host sends 42 34 12 44:
  - TX bytes A5 01 23 45 2F xx xx;
  - bus_dout=0x1234;
  - dtack rises one cycle after rx of 44 and clears one cycle after as_fall.
- Write 0xBEEF at 0x000100, LDS only, tx_busy toggling every other cycle:
  - exactly 7 bytes, each presented only while tx_busy=0;
  - signal byte 0x29 (FC=5, RW=0, LDS only), data bytes BE EF;
  - host 45 -> berr=1, dtack=0.
- TIMEOUT_CYCLES=100, no host reply:
  - berr and timeout_evt one cycle after counter reaches 99 (100 cycles after strobe_rise);
  - a 'D' sent afterwards is ignored.
- 'D' on the exact cycle the timeout expires:
  - dtack=1, berr=0, no timeout_evt.
- 'R' mid-frame:
  - ignored.
- 'R' after the frame completes with C_PENDING:
  - identical 7-byte frame resent;
  - 'D' while C_IDLE has no effect.
- rst and bus_reset, each asserted during address byte 2 with dtack pending:
  - all outputs 0 next cycle, no further tx_new;
  - the next strobe starts a clean frame with A5.
